// File: rtl/Purple_Jade_pkg.sv
// Shared types and sizing for the ALU reservation station and its CDB.
// Station entries, CDB record and the common operand wakeup rule live here.
package Purple_Jade_pkg;
  localparam int RS_ENTRY     = 4;
  localparam int WIDTH_OP     = 4;
  localparam int WORD_SIZE_P  = 32;
  localparam int NUM_PHYS_REG = 64;
  localparam int ROB_ENTRY    = 16;
  localparam int CDB_FLAGS_W  = 4;

  localparam int TAG_W    = $clog2(NUM_PHYS_REG);
  localparam int ROB_W    = $clog2(ROB_ENTRY);
  localparam int RS_IDX_W = $clog2(RS_ENTRY);
  localparam int RS_CNT_W = $clog2(RS_ENTRY + 1);

  typedef struct packed {
    logic                   valid;
    logic [TAG_W-1:0]       dest;
    logic [CDB_FLAGS_W-1:0] flags;
    logic [WORD_SIZE_P-1:0] result;
  } CDB_t;

  localparam int CDB_WIDTH = $bits(CDB_t);

  typedef struct packed {
    logic                   rdy;
    logic [TAG_W-1:0]       tag;
    logic [WORD_SIZE_P-1:0] val;
  } rs_src_t;

  typedef struct packed {
    logic                valid;
    logic [WIDTH_OP-1:0] opcode;
    logic                w_v;
    rs_src_t             src1;
    rs_src_t             src2;
    logic [ROB_W-1:0]    rob_dest;
    logic [TAG_W-1:0]    reg_dest;
  } rs_entry_t;

  // Same capture rule serves both stored-entry wakeup and dispatch bypass.
  function automatic rs_src_t src_wake(input rs_src_t s, input CDB_t c);
    rs_src_t r;
    r = s;
    if (!s.rdy && c.valid && (c.dest == s.tag)) begin
      r.rdy = 1'b1;
      r.val = c.result;
    end
    return r;
  endfunction
endpackage

// File: rtl/alu_rs_if.sv
// Dispatch and issue bundle between rename/dispatch, the ALU station and fu_alu.
interface alu_rs_if;
  import Purple_Jade_pkg::*;

  logic                   dispatch_v_i;
  logic                   dispatch_ready_o;
  logic [WIDTH_OP-1:0]    opcode_i;
  logic                   w_v_i;
  logic                   src1_rdy_i;
  logic                   src2_rdy_i;
  logic [TAG_W-1:0]       src1_tag_i;
  logic [TAG_W-1:0]       src2_tag_i;
  logic [WORD_SIZE_P-1:0] src1_val_i;
  logic [WORD_SIZE_P-1:0] src2_val_i;
  logic [ROB_W-1:0]       rob_dest_i;
  logic [TAG_W-1:0]       reg_dest_i;

  logic                   exe_v_o;
  logic                   w_v_o;
  logic [WIDTH_OP-1:0]    opcode_o;
  logic [WORD_SIZE_P-1:0] operand1_o;
  logic [WORD_SIZE_P-1:0] operand2_o;
  logic [ROB_W-1:0]       rob_dest_o;
  logic [TAG_W-1:0]       reg_dest_o;

  modport master (
    output dispatch_v_i, opcode_i, w_v_i, src1_rdy_i, src2_rdy_i,
           src1_tag_i, src2_tag_i, src1_val_i, src2_val_i, rob_dest_i, reg_dest_i,
    input  dispatch_ready_o, exe_v_o, w_v_o, opcode_o, operand1_o, operand2_o,
           rob_dest_o, reg_dest_o
  );

  modport slave (
    input  dispatch_v_i, opcode_i, w_v_i, src1_rdy_i, src2_rdy_i,
           src1_tag_i, src2_tag_i, src1_val_i, src2_val_i, rob_dest_i, reg_dest_i,
    output dispatch_ready_o, exe_v_o, w_v_o, opcode_o, operand1_o, operand2_o,
           rob_dest_o, reg_dest_o
  );
endinterface

// File: rtl/alu_rs_select.sv
// Oldest-ready pick: lowest set bit of the ready vector, plus a found flag.
module rs_select
  import Purple_Jade_pkg::*;
(
  input  logic [RS_ENTRY-1:0] i_req,
  output logic [RS_IDX_W-1:0] o_idx,
  output logic                o_found
);
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = RS_ENTRY - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx   = RS_IDX_W'(i);
        o_found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: collapsing queue with CDB wakeup/bypass and
// registered single-issue to fu_alu.
module alu_rs
  import Purple_Jade_pkg::*;
(
  input  logic     clk_i,
  input  logic     reset_i,
  input  logic     flush_i,
  input  CDB_t     cdb_i,
  alu_rs_if.slave  bus
);
  rs_entry_t               r_ent [RS_ENTRY];
  logic [RS_CNT_W-1:0]     r_count;
  logic                    r_exe_v;
  logic                    r_w_v;
  logic [WIDTH_OP-1:0]     r_opcode;
  logic [WORD_SIZE_P-1:0]  r_op1;
  logic [WORD_SIZE_P-1:0]  r_op2;
  logic [ROB_W-1:0]        r_rob;
  logic [TAG_W-1:0]        r_reg;

  logic [RS_ENTRY-1:0]     w_req;
  logic [RS_IDX_W-1:0]     w_sel_idx;
  logic                    w_found;
  logic                    w_ready;
  logic                    w_disp_acc;
  logic [RS_CNT_W-1:0]     w_cnt_shift;
  rs_entry_t               w_new;
  rs_entry_t               w_sel;
  // One spare slot on top so the shift always has a (empty) source.
  rs_entry_t               w_woke [RS_ENTRY+1];
  rs_entry_t               w_nxt  [RS_ENTRY];

  for (genvar g = 0; g < RS_ENTRY; g++) begin : g_req
    assign w_req[g] = r_ent[g].valid & r_ent[g].src1.rdy & r_ent[g].src2.rdy;
  end

  rs_select u_sel (
    .i_req   (w_req),
    .o_idx   (w_sel_idx),
    .o_found (w_found)
  );

  assign w_ready     = (r_count < RS_CNT_W'(RS_ENTRY));
  assign w_disp_acc  = bus.dispatch_v_i & w_ready & ~flush_i;
  assign w_cnt_shift = r_count - RS_CNT_W'(w_found);
  assign w_sel       = r_ent[w_sel_idx];

  always_comb begin
    w_new          = '0;
    w_new.valid    = 1'b1;
    w_new.opcode   = bus.opcode_i;
    w_new.w_v      = bus.w_v_i;
    w_new.src1     = src_wake('{rdy: bus.src1_rdy_i, tag: bus.src1_tag_i, val: bus.src1_val_i}, cdb_i);
    w_new.src2     = src_wake('{rdy: bus.src2_rdy_i, tag: bus.src2_tag_i, val: bus.src2_val_i}, cdb_i);
    w_new.rob_dest = bus.rob_dest_i;
    w_new.reg_dest = bus.reg_dest_i;
  end

  // Wake first, then collapse, so captured values travel with their entry.
  always_comb begin
    for (int i = 0; i <= RS_ENTRY; i++) w_woke[i] = '0;
    for (int i = 0; i < RS_ENTRY; i++) begin
      w_woke[i] = r_ent[i];
      if (r_ent[i].valid) begin
        w_woke[i].src1 = src_wake(r_ent[i].src1, cdb_i);
        w_woke[i].src2 = src_wake(r_ent[i].src2, cdb_i);
      end
    end
    for (int i = 0; i < RS_ENTRY; i++) begin
      if (w_found && (RS_IDX_W'(i) >= w_sel_idx)) w_nxt[i] = w_woke[i+1];
      else                                        w_nxt[i] = w_woke[i];
      if (w_disp_acc && (RS_CNT_W'(i) == w_cnt_shift)) w_nxt[i] = w_new;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      for (int i = 0; i < RS_ENTRY; i++) r_ent[i] <= '0;
      r_count  <= '0;
      r_exe_v  <= 1'b0;
      r_w_v    <= 1'b0;
      r_opcode <= '0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_rob    <= '0;
      r_reg    <= '0;
    end else begin
      r_ent    <= w_nxt;
      r_count  <= w_cnt_shift + RS_CNT_W'(w_disp_acc);
      r_exe_v  <= w_found;
      r_w_v    <= w_found & w_sel.w_v;
      r_opcode <= w_sel.opcode;
      r_op1    <= w_sel.src1.val;
      r_op2    <= w_sel.src2.val;
      r_rob    <= w_sel.rob_dest;
      r_reg    <= w_sel.reg_dest;
    end
  end

  assign bus.dispatch_ready_o = w_ready;
  assign bus.exe_v_o          = r_exe_v;
  assign bus.w_v_o            = r_w_v;
  assign bus.opcode_o         = r_opcode;
  assign bus.operand1_o       = r_op1;
  assign bus.operand2_o       = r_op2;
  assign bus.rob_dest_o       = r_rob;
  assign bus.reg_dest_o       = r_reg;
endmodule

// File: tb/tb_alu_rs.sv
// Randomized + directed bench for alu_rs: queue-level reference model feeds a
// scoreboard that an independent output monitor drains.
module tb_alu_rs;
  import Purple_Jade_pkg::*;

  typedef struct {
    logic [WIDTH_OP-1:0]    op;
    logic                   wv;
    bit                     r1, r2;
    logic [TAG_W-1:0]       t1, t2;
    logic [WORD_SIZE_P-1:0] v1, v2;
    logic [ROB_W-1:0]       rob;
    logic [TAG_W-1:0]       rd;
  } m_ent_t;

  typedef struct {
    int                     cyc;
    logic [WORD_SIZE_P-1:0] v1, v2;
    logic [WIDTH_OP+1+ROB_W+TAG_W-1:0] meta;
  } exp_t;

  logic clk = 1'b0;
  logic reset, flush;
  CDB_t cdb;
  alu_rs_if bus ();

  alu_rs dut (.clk_i(clk), .reset_i(reset), .flush_i(flush), .cdb_i(cdb), .bus(bus));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  m_ent_t mq[$];
  exp_t   sb[$];
  int     n_chk = 0, n_fail = 0;
  bit     mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic m_ent_t ent(input int op, input bit r1, input int t1, input int v1,
                                 input bit r2, input int t2, input int v2, input int rob, input int rd);
    m_ent_t e;
    e.op = WIDTH_OP'(op); e.wv = 1'b1;
    e.r1 = r1; e.t1 = TAG_W'(t1); e.v1 = WORD_SIZE_P'(v1);
    e.r2 = r2; e.t2 = TAG_W'(t2); e.v2 = WORD_SIZE_P'(v2);
    e.rob = ROB_W'(rob); e.rd = TAG_W'(rd);
    return e;
  endfunction

  // Drive one cycle and advance the model; returns 1ns after the closing edge.
  task automatic step(input bit dv, input m_ent_t d, input bit cv, input int cdest,
                      input logic [WORD_SIZE_P-1:0] cres, input bit fl, input bit rs);
    int  sel;
    bit  rdy;
    exp_t x;
    m_ent_t e;
    reset = rs; flush = fl;
    bus.dispatch_v_i = dv;  bus.opcode_i = d.op;  bus.w_v_i = d.wv;
    bus.src1_rdy_i = d.r1;  bus.src1_tag_i = d.t1; bus.src1_val_i = d.v1;
    bus.src2_rdy_i = d.r2;  bus.src2_tag_i = d.t2; bus.src2_val_i = d.v2;
    bus.rob_dest_i = d.rob; bus.reg_dest_i = d.rd;
    cdb.valid = cv; cdb.dest = TAG_W'(cdest); cdb.flags = CDB_FLAGS_W'($urandom); cdb.result = cres;
    rdy = (mq.size() < RS_ENTRY);
    if (!rs) chk("dispatch_ready", 64'(bus.dispatch_ready_o), 64'(rdy));
    if (rs || fl) mq.delete();
    else begin
      sel = -1;
      foreach (mq[i]) if (sel < 0 && mq[i].r1 && mq[i].r2) sel = i;
      if (sel >= 0) begin
        x.cyc = cyc + 1; x.v1 = mq[sel].v1; x.v2 = mq[sel].v2;
        x.meta = {mq[sel].op, mq[sel].wv, mq[sel].rob, mq[sel].rd};
        sb.push_back(x);
      end
      foreach (mq[i]) begin
        if (cv && !mq[i].r1 && mq[i].t1 == TAG_W'(cdest)) begin mq[i].r1 = 1; mq[i].v1 = cres; end
        if (cv && !mq[i].r2 && mq[i].t2 == TAG_W'(cdest)) begin mq[i].r2 = 1; mq[i].v2 = cres; end
      end
      if (sel >= 0) mq.delete(sel);
      if (dv && rdy) begin
        e = d;
        if (cv && !e.r1 && e.t1 == TAG_W'(cdest)) begin e.r1 = 1; e.v1 = cres; end
        if (cv && !e.r2 && e.t2 == TAG_W'(cdest)) begin e.r2 = 1; e.v2 = cres; end
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  m_ent_t nil;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, nil, 0, 0, '0, 0, 0);
  endtask

  task automatic disp(input m_ent_t d);
    step(1, d, 0, 0, '0, 0, 0);
  endtask

  task automatic wake(input int tag, input int val);
    step(0, nil, 1, tag, WORD_SIZE_P'(val), 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (bus.exe_v_o === 1'b1) begin
        if (sb.size() == 0) chk("unexpected_issue", 64'(bus.exe_v_o), 64'd0);
        else begin
          e = sb.pop_front();
          chk("issue_cycle", 64'(cyc), 64'(e.cyc));
          chk("operand1", 64'(bus.operand1_o), 64'(e.v1));
          chk("operand2", 64'(bus.operand2_o), 64'(e.v2));
          chk("op_wv_rob_reg", 64'({bus.opcode_o, bus.w_v_o, bus.rob_dest_o, bus.reg_dest_o}), 64'(e.meta));
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        chk("missing_issue", 64'(bus.exe_v_o), 64'd1);
      end
    end
  end

  initial begin
    nil = ent(0, 1, 0, 0, 1, 0, 0, 0, 0);
    reset = 1'b1; flush = 1'b0; cdb = '0;
    bus.dispatch_v_i = 0; bus.opcode_i = '0; bus.w_v_i = 0;
    bus.src1_rdy_i = 0; bus.src2_rdy_i = 0; bus.src1_tag_i = '0; bus.src2_tag_i = '0;
    bus.src1_val_i = '0; bus.src2_val_i = '0; bus.rob_dest_i = '0; bus.reg_dest_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_exe_v", 64'(bus.exe_v_o), 64'd0);
    chk("rst_w_v", 64'(bus.w_v_o), 64'd0);
    chk("rst_outs", 64'({bus.opcode_o, bus.rob_dest_o, bus.reg_dest_o}), 64'd0);
    chk("rst_operands", {bus.operand1_o, bus.operand2_o}, 64'd0);
    chk("rst_ready", 64'(bus.dispatch_ready_o), 64'd1);
    mon_en = 1'b1;

    // Both ready: ADD 3,4 issues two cycles after dispatch.
    disp(ent(1, 1, 0, 3, 1, 0, 4, 5, 33)); idle(3);
    // Wakeup of src2 (tag 7) by CDB three cycles after dispatch.
    disp(ent(2, 1, 0, 1, 0, 7, 0, 6, 34)); idle(2); wake(7, 9); idle(3);
    // Dispatch bypass with a same-cycle CDB.
    step(1, ent(3, 0, 5, 0, 1, 0, 2, 7, 35), 1, 5, 32'h55, 0, 0); idle(3);
    // Fill, drop a fifth dispatch, wake entry 2 first.
    for (int i = 0; i < 4; i++) disp(ent(i, 0, 10 + i, 0, 1, 0, i, i, 40 + i));
    disp(ent(9, 1, 0, 1, 1, 0, 1, 9, 49));
    wake(12, 100); idle(2); wake(10, 101); wake(11, 102); wake(13, 103); idle(4);
    // Entries 0 and 2 ready together: oldest first.
    disp(ent(4, 0, 20, 0, 1, 0, 1, 1, 50)); disp(ent(5, 0, 21, 0, 1, 0, 2, 2, 51));
    disp(ent(6, 0, 20, 0, 1, 0, 3, 3, 52)); wake(20, 200); idle(2); wake(21, 201); idle(3);
    // Flush with three ready entries and an issue pending.
    for (int i = 0; i < 3; i++) disp(ent(7, 1, 0, i, 1, 0, i, i, 60 + i));
    step(0, nil, 0, 0, '0, 1, 0);
    chk("flush_exe_v", 64'(bus.exe_v_o), 64'd0);
    chk("flush_ready", 64'(bus.dispatch_ready_o), 64'd1);
    idle(2);
    // Same scenario ended by a mid-stream reset.
    for (int i = 0; i < 3; i++) disp(ent(8, 1, 0, i, 1, 0, i, i, 60 + i));
    step(0, nil, 0, 0, '0, 0, 1);
    chk("reset_exe_v", 64'(bus.exe_v_o), 64'd0);
    chk("reset_ready", 64'(bus.dispatch_ready_o), 64'd1);
    idle(2);

    for (int n = 0; n < 3000; n++) begin
      m_ent_t d;
      d = ent($urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
              $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
              $urandom_range(0, 15), $urandom_range(0, 63));
      d.wv = $urandom_range(0, 1);
      step($urandom_range(0, 9) < 6, d, $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
           $urandom_range(0, 49) == 0, $urandom_range(0, 299) == 0);
    end
    for (int i = 0; i < 8; i++) wake(i, 32'hA0 + i);
    idle(6);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    chk("model_drained", 64'(mq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 RS_ENTRY, default 4 (package constant), number of station entries.
REQ-002 clk_i  in  1  clock; all state updates on its rising edge.
REQ-003 reset_i  in  1  reset; synchronous and active-high.
REQ-004 flush_i  in  1  discard all entries and any pending issue.
REQ-005 dispatch_v_i  in  1  dispatch request this cycle.
REQ-006 dispatch_ready_o  out  1  station can accept a dispatch this cycle.
REQ-007 opcode_i  in  WIDTH_OP  ALU opcode.
REQ-008 w_v_i  in  1  instruction writes a register.
REQ-009 src1_rdy_i, src2_rdy_i  in  1 each  operand value already valid.
REQ-010 src1_tag_i, src2_tag_i  in  $clog2(NUM_PHYS_REG) each  producer physical register.
REQ-011 src1_val_i, src2_val_i  in  WORD_SIZE_P each  operand value, used only when the rdy bit is set.
REQ-012 rob_dest_i  in  $clog2(ROB_ENTRY)  ROB index; reg_dest_i  in  $clog2(NUM_PHYS_REG)  destination.
REQ-013 cdb_i  in  CDB_WIDTH  broadcast as CDB_t {valid, dest, flags, result}.
REQ-014 exe_v_o, w_v_o  out  1 each  issue valid and write-valid to fu_alu.
REQ-015 opcode_o  out  WIDTH_OP; operand1_o, operand2_o  out  WORD_SIZE_P each.
REQ-016 rob_dest_o, reg_dest_o  out  same widths as REQ-012.

Function
REQ-017 The station SHALL be a collapsing queue: entry 0 is oldest, and new entries go to index = current count.
REQ-018 dispatch_ready_o SHALL equal (count < RS_ENTRY), computed from registered count only; an issue in the same cycle gives no extra credit.
REQ-019 A dispatch SHALL be accepted iff dispatch_v_i & dispatch_ready_o & ~flush_i; otherwise it is dropped.
REQ-020 Wakeup: for each valid entry source not ready, if cdb_i.valid and cdb_i.dest equals its tag, the station SHALL capture cdb_i.result and set ready at the edge.
REQ-021 Dispatch bypass: an accepted source with rdy=0 whose tag matches a valid CDB in the same cycle SHALL be stored ready with cdb_i.result.
REQ-022 Select: the lowest-index valid entry with both sources ready (registered state) SHALL be issued that cycle. At most one issue per cycle.
REQ-023 Issue outputs SHALL be registered: the entry selected in cycle t drives exe_v_o=1 and its fields during t+1. exe_v_o=0 when nothing is selected.
REQ-024 The entry woken in cycle t SHALL be selectable no earlier than cycle t+1. Dispatch-to-exe_v_o minimum latency is 2 cycles.
REQ-025 On issue, entries above the selected index SHALL shift down by one. An accepted dispatch in the same cycle SHALL land at index count-1.
REQ-026 Wakeup SHALL apply to entries during a shift; a captured value follows its entry to its new index.
REQ-027 fu_alu never stalls, so there is no issue back-pressure.
REQ-028 flush_i SHALL clear all valid bits and count, and force exe_v_o=0 at the next edge. A flush overrides a simultaneous dispatch, wakeup and issue.
REQ-029 The station SHALL issue operands unmodified; any CDB with valid=0 SHALL be ignored.

Reset
REQ-030 On reset_i all entry valid bits, count, exe_v_o and w_v_o SHALL be 0. All other outputs are 0.
REQ-031 Reset SHALL take precedence over flush_i and dispatch_v_i. A mid-operation reset discards all entries within one cycle.

Structure
REQ-032 rs_entry_t (valid, opcode, w_v, per-source rdy/tag/val, rob_dest, reg_dest) and RS_ENTRY SHALL live in Purple_Jade_pkg. Ports use the existing CDB_t.
REQ-033 Oldest-ready selection SHALL be a sub-module rs_select: a priority encoder giving index plus found bit from the RS_ENTRY ready vector.

Verification
REQ-034 Both sources ready: dispatch ADD 3,4 to empty RS at cycle 0 -> exe_v_o=1 at cycle 2 with operand1_o=3, operand2_o=4, same rob/reg dest.
REQ-035 Wakeup: dispatch with src2 tag 7 not ready; CDB {valid,dest=7,result=9} at cycle 3 -> issue at cycle 5 with operand2_o=9.
REQ-036 Dispatch bypass: dispatch src1 tag 5 not ready while CDB dest=5, result=0x55 in the same cycle -> issue 2 cycles later with operand1_o=0x55.
REQ-037 Full: 4 dispatches with unready sources -> dispatch_ready_o=0, and a 5th dispatch is dropped. Wake entry 2 -> it issues first, entry 3 shifts to 2, and ready returns the next cycle.
REQ-038 Ordering: entries 0 and 2 become ready in the same cycle -> entry 0 issues first, then the former entry 2 the next cycle.
REQ-039 Flush with 3 entries and an issue pending -> next cycle exe_v_o=0, count=0, dispatch_ready_o=1. A reset mid-stream gives the same result.
